// File: rtl/imem_loader_pkg.sv
// Shared constants and state type for the instruction-memory loader.
package imem_loader_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Loader control, word-stream and memory-write signals grouped as one bundle.
interface imem_loader_if #(
  parameter int INSTR_W = imem_loader_pkg::INSTR_W,
  parameter int ADDR_W  = imem_loader_pkg::ADDR_W
);

  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [ADDR_W:0]    word_count;
  logic               abort;
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               core_hold;
  logic               busy;
  logic               done;
  logic               error;
  logic [INSTR_W-1:0] checksum;

  modport master (
    output start, base_addr, word_count, abort, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, error, checksum
  );

  modport slave (
    input  start, base_addr, word_count, abort, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, error, checksum
  );

endinterface

// File: rtl/imem_loader.sv
// Streams a counted block of instruction words into the instruction memory
// while holding the core in reset; tracks a running checksum of written words.
module imem_loader #(
  parameter int INSTR_W = imem_loader_pkg::INSTR_W,
  parameter int ADDR_W  = imem_loader_pkg::ADDR_W
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);

  import imem_loader_pkg::*;

  localparam logic [ADDR_W:0] ZERO_WC = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] ONE_WC  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] MAX_WC  = {1'b1, {ADDR_W{1'b0}}};

  loader_state_e      r_state;
  loader_state_e      w_next_state;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W:0]    r_word_count;
  logic [ADDR_W:0]    r_count;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [INSTR_W-1:0] r_mem_wdata;
  logic               r_core_hold;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [INSTR_W-1:0] r_checksum;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_last;
  logic               w_wc_ok;
  logic               w_start_acc;
  logic               w_start_rej;
  logic               w_abort;
  logic [ADDR_W:0]    w_count_nxt;
  logic               w_we_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [INSTR_W-1:0] w_wdata_nxt;
  logic               w_hold_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_error_nxt;
  logic [INSTR_W-1:0] w_sum_nxt;

  assign w_in_ready  = (r_state == ST_LOAD);
  assign w_accept    = w_in_ready & bus.in_valid;
  assign w_last      = ((r_count + ONE_WC) == r_word_count);
  assign w_wc_ok     = (bus.word_count != ZERO_WC) && (bus.word_count <= MAX_WC);
  assign w_start_acc = (r_state == ST_IDLE) & bus.start & w_wc_ok;
  assign w_start_rej = (r_state == ST_IDLE) & bus.start & ~w_wc_ok;
  assign w_abort     = w_in_ready & bus.abort;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort wins over completion of the last word.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_accept && w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the hold stays up for a trailing write after abort.
  always_comb begin
    w_busy_nxt = (w_next_state != ST_IDLE);
    w_done_nxt = (w_next_state == ST_DONE);
    w_hold_nxt = w_busy_nxt | w_accept;
    w_we_nxt   = w_accept;
    if (w_accept) begin
      w_addr_nxt  = r_base + r_count[ADDR_W-1:0];
      w_wdata_nxt = bus.in_data;
      w_sum_nxt   = r_checksum + bus.in_data;
      w_count_nxt = r_count + ONE_WC;
    end else if (w_start_acc) begin
      w_addr_nxt  = r_mem_addr;
      w_wdata_nxt = r_mem_wdata;
      w_sum_nxt   = {INSTR_W{1'b0}};
      w_count_nxt = ZERO_WC;
    end else begin
      w_addr_nxt  = r_mem_addr;
      w_wdata_nxt = r_mem_wdata;
      w_sum_nxt   = r_checksum;
      w_count_nxt = r_count;
    end
    if (w_start_acc) begin
      w_error_nxt = 1'b0;
    end else if (w_start_rej || w_abort) begin
      w_error_nxt = 1'b1;
    end else begin
      w_error_nxt = r_error;
    end
  end

  // Session parameters, word counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base       <= {ADDR_W{1'b0}};
      r_word_count <= ZERO_WC;
      r_count      <= ZERO_WC;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {INSTR_W{1'b0}};
      r_core_hold  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_checksum   <= {INSTR_W{1'b0}};
    end else begin
      if (w_start_acc) begin
        r_base       <= bus.base_addr;
        r_word_count <= bus.word_count;
      end else begin
        r_base       <= r_base;
        r_word_count <= r_word_count;
      end
      r_count     <= w_count_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_core_hold <= w_hold_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_checksum  <= w_sum_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.core_hold = r_core_hold;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.checksum  = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a session-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_imem_loader;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_loader_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

  imem_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Session model: words enter while a session is open; each becomes one write a cycle later.
  bit   m_sess   = 1'b0;
  bit   m_err    = 1'b0;
  int   m_base   = 0;
  int   m_total  = 0;
  int   m_cnt    = 0;
  int   m_sum    = 0;
  bit   e_we     = 1'b0;
  bit   e_done   = 1'b0;
  int   e_addr   = 0;
  int   e_data   = 0;
  wire  m_acc    = m_sess && bus.in_valid;
  wire  m_fin    = m_acc && !bus.abort && ((m_cnt + 1) == m_total);
  wire  m_ok     = (bus.word_count >= 1) && (bus.word_count <= DEPTH);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sess <= 1'b0; m_err <= 1'b0; m_base <= 0; m_total <= 0; m_cnt <= 0; m_sum <= 0;
      e_we <= 1'b0; e_done <= 1'b0; e_addr <= 0; e_data <= 0;
    end else begin
      e_we   <= m_acc;
      e_done <= m_fin;
      if (m_acc) begin
        e_addr <= (m_base + m_cnt) % DEPTH;
        e_data <= int'(bus.in_data);
        m_sum  <= (m_sum + int'(bus.in_data)) % 65536;
        m_cnt  <= m_cnt + 1;
      end
      if (m_sess) begin
        if (bus.abort || m_fin) m_sess <= 1'b0;
        if (bus.abort) m_err <= 1'b1;
      end else if (bus.start && !e_done) begin
        if (m_ok) begin
          m_sess <= 1'b1; m_base <= int'(bus.base_addr); m_total <= int'(bus.word_count);
          m_cnt <= 0; m_sum <= 0; m_err <= 1'b0;
        end else begin
          m_err <= 1'b1;
        end
      end
    end
  end

  logic [7:0]  log_addr[$];
  logic [15:0] log_data[$];
  int          done_cnt = 0;

  // Per-cycle comparison against the model, plus a log of every write seen.
  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, m_sess);
    chk("mem_we", bus.mem_we, e_we);
    if (e_we) begin
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_data);
    end
    chk("done", bus.done, e_done);
    chk("busy", bus.busy, m_sess || e_done);
    chk("core_hold", bus.core_hold, m_sess || e_done || e_we);
    chk("error", bus.error, m_err);
    chk("checksum", bus.checksum, m_sum);
    if (bus.mem_we) begin
      log_addr.push_back(bus.mem_addr);
      log_data.push_back(bus.mem_wdata);
    end
    if (bus.done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base, input logic [8:0] wc);
    bus.start = 1'b1; bus.base_addr = base; bus.word_count = wc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    int waited = 0;
    bus.in_valid = 1'b1; bus.in_data = w;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("accept_timeout", bus.in_ready, 1'b1);
    tick();
  endtask

  initial begin
    int n0;
    int d0;
    logic [15:0] w43 [4];
    w43 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) tick();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_hold", bus.core_hold, 1'b0);
    chk("reset_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    tick();

    // Four words at base 0, valid held high.
    n0 = log_addr.size();
    do_start(8'h00, 9'd4);
    chk("s1_busy", bus.busy, 1'b1);
    chk("s1_hold", bus.core_hold, 1'b1);
    for (int i = 0; i < 4; i++) send_word(w43[i]);
    chk("s1_done_pulse", bus.done, 1'b1);
    chk("s1_last_addr", bus.mem_addr, 8'h03);
    chk("s1_last_we", bus.mem_we, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk("s1_done_low", bus.done, 1'b0);
    chk("s1_hold_low", bus.core_hold, 1'b0);
    tick();
    chk("s1_nwrites", log_addr.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("s1_log_addr", log_addr[n0 + i], i);
      chk("s1_log_data", log_data[n0 + i], w43[i]);
    end
    chk("s1_checksum", bus.checksum, 16'hAAAA);
    chk("s1_done_cnt", done_cnt, 1);

    // Address wrap at the top of memory.
    n0 = log_addr.size();
    do_start(8'hFE, 9'd3);
    send_word(16'h000A);
    send_word(16'h000B);
    send_word(16'h000C);
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("s2_nwrites", log_addr.size() - n0, 3);
    chk("s2_addr0", log_addr[n0], 8'hFE);
    chk("s2_addr1", log_addr[n0 + 1], 8'hFF);
    chk("s2_addr2", log_addr[n0 + 2], 8'h00);
    chk("s2_data2", log_data[n0 + 2], 16'h000C);
    chk("s2_checksum", bus.checksum, 16'h0021);
    chk("s2_error", bus.error, 1'b0);

    // Rejected starts, then a valid start clears error.
    n0 = log_addr.size();
    do_start(8'h10, 9'd0);
    tick();
    chk("s3_err_zero", bus.error, 1'b1);
    chk("s3_busy_zero", bus.busy, 1'b0);
    do_start(8'h10, 9'd257);
    tick();
    chk("s3_err_257", bus.error, 1'b1);
    chk("s3_ready_257", bus.in_ready, 1'b0);
    chk("s3_nwrites", log_addr.size() - n0, 0);
    do_start(8'h10, 9'd256);
    chk("s3_err_clear", bus.error, 1'b0);
    chk("s3_busy", bus.busy, 1'b1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();

    // Toggled valid, abort after three accepts.
    n0 = log_addr.size();
    d0 = done_cnt;
    do_start(8'h20, 9'd8);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'h0100 + 16'(i);
      tick();
      bus.in_valid = 1'b0;
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (2) tick();
    chk("s4_nwrites", log_addr.size() - n0, 3);
    chk("s4_last_addr", log_addr[n0 + 2], 8'h22);
    chk("s4_error", bus.error, 1'b1);
    chk("s4_no_done", done_cnt - d0, 0);
    chk("s4_hold", bus.core_hold, 1'b0);
    chk("s4_checksum", bus.checksum, 16'h0303);

    // Word accepted together with abort is still written.
    n0 = log_addr.size();
    do_start(8'h80, 9'd4);
    send_word(16'h0070);
    bus.in_data = 16'h0077; bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("s5_nwrites", log_addr.size() - n0, 2);
    chk("s5_addr", log_addr[n0 + 1], 8'h81);
    chk("s5_data", log_data[n0 + 1], 16'h0077);

    // Reset in the middle of a session.
    do_start(8'h40, 9'd5);
    send_word(16'h0100);
    send_word(16'h0200);
    rst = 1'b0;
    #1;
    chk("s6_we", bus.mem_we, 1'b0);
    chk("s6_addr", bus.mem_addr, 8'h00);
    chk("s6_wdata", bus.mem_wdata, 16'h0000);
    chk("s6_sum", bus.checksum, 16'h0000);
    chk("s6_busy", bus.busy, 1'b0);
    chk("s6_hold", bus.core_hold, 1'b0);
    chk("s6_ready", bus.in_ready, 1'b0);
    chk("s6_error", bus.error, 1'b0);
    n0 = log_addr.size();
    repeat (3) tick();
    chk("s6_no_write", log_addr.size() - n0, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    do_start(8'h00, 9'd1);
    send_word(16'hBEEF);
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("s6_checksum", bus.checksum, 16'hBEEF);
    chk("s6_new_write", log_data[log_data.size() - 1], 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
